// File: rtl/audio_pkg.sv
// audio_pkg: shared audio types and I2S frame constants.
// Used by the mixer, the serializer and the upstream sample sources.
package audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_CNT_W = 11;
  localparam int SLOT_MSB    = 1;
  localparam int SLOT_LSB    = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_serializer.sv
// i2s_serializer: frame counter, DAC clock decode and I2S data shifter.
// Outputs are registered from the next count so they line up with cnt.
module i2s_serializer
  import audio_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word,
  output logic              sample_tick,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic              sdin
);

  localparam int IW = $clog2(WORD_W);

  logic [FRAME_CNT_W-1:0] cnt;
  logic [FRAME_CNT_W-1:0] cnt_nx;
  logic                   run;
  logic [WORD_W-1:0]      word_q;
  logic [4:0]             slot_nx;
  logic [IW-1:0]          idx;
  logic                   bit_nx;

  // The first edge after reset presents cnt == 0 without advancing.
  always_comb begin
    cnt_nx  = run ? cnt + FRAME_CNT_W'(1) : cnt;
    slot_nx = cnt_nx[9:5];
    idx     = IW'(WORD_W - int'(slot_nx));
    bit_nx  = 1'b0;
    if (int'(slot_nx) >= SLOT_MSB &&
        int'(slot_nx) <= SLOT_LSB)
      bit_nx = word_q[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      run         <= 1'b0;
      word_q      <= '0;
      sample_tick <= 1'b0;
      mclk        <= 1'b0;
      sclk        <= 1'b0;
      lrck        <= 1'b0;
      sdin        <= 1'b0;
    end else begin
      run         <= 1'b1;
      cnt         <= cnt_nx;
      if (run && cnt == '0)
        word_q <= word;
      sample_tick <= (cnt_nx == '0);
      mclk        <= cnt_nx[1];
      sclk        <= cnt_nx[4];
      lrck        <= cnt_nx[10];
      sdin        <= bit_nx;
    end
  end

endmodule

// File: rtl/audio_mixer_i2s.sv
// audio_mixer_i2s: saturating BGM+SFX mix with volume/mute, I2S out.
// Define AUDIO_MIXER_DUCK_EN to halve BGM while an effect is non-zero.
module audio_mixer_i2s
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] bgm_sample,
  input  logic signed [SAMPLE_W-1:0] sfx_sample,
  input  logic        [VOL_W-1:0]    volume,
  input  logic                       mute,
  output logic                       sample_tick,
  output logic                       mclk,
  output logic                       sclk,
  output logic                       lrck,
  output logic                       sdin
);

  logic signed [SAMPLE_W-1:0] bgm_eff;
  logic signed [SAMPLE_W:0]   sum;
  logic                       ovf;
  logic signed [SAMPLE_W-1:0] sat;
  logic signed [SAMPLE_W-1:0] shifted;
  logic        [SAMPLE_W-1:0] mixed;

`ifdef AUDIO_MIXER_DUCK_EN
  assign bgm_eff = (sfx_sample != '0) ?
                   (bgm_sample >>> 1) : bgm_sample;
`else
  assign bgm_eff = bgm_sample;
`endif

  assign sum = {bgm_eff[SAMPLE_W-1], bgm_eff} +
               {sfx_sample[SAMPLE_W-1], sfx_sample};

  // Sign bits disagree only when the 16-bit range was exceeded.
  assign ovf = sum[SAMPLE_W] ^ sum[SAMPLE_W-1];
  assign sat = ovf ?
    {sum[SAMPLE_W], {(SAMPLE_W-1){~sum[SAMPLE_W]}}} :
    sum[SAMPLE_W-1:0];

  assign shifted = sat >>> volume;
  assign mixed   = mute ? '0 : shifted;

  i2s_serializer #(
    .WORD_W(SAMPLE_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .word       (mixed),
    .sample_tick(sample_tick),
    .mclk       (mclk),
    .sclk       (sclk),
    .lrck       (lrck),
    .sdin       (sdin)
  );

endmodule

// File: tb/tb_audio_mixer_i2s.sv
// tb_audio_mixer_i2s: directed frames for audio_mixer_i2s.
// Expected DAC words are hand-computed per vector.
module tb_audio_mixer_i2s;

`ifdef AUDIO_MIXER_DUCK_EN
  localparam bit DUCK = 1'b1;
`else
  localparam bit DUCK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] bgm;
  logic [15:0] sfx;
  logic [2:0]  volume;
  logic        mute;
  logic        sample_tick;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdin;

  int checks = 0;
  int errors = 0;

  audio_mixer_i2s #(
    .SAMPLE_W(16),
    .VOL_W   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bgm_sample (bgm),
    .sfx_sample (sfx),
    .volume     (volume),
    .mute       (mute),
    .sample_tick(sample_tick),
    .mclk       (mclk),
    .sclk       (sclk),
    .lrck       (lrck),
    .sdin       (sdin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in a tick cycle (cnt == 0); leaves in the next one.
  task automatic frame_chk(input string tag,
                           input logic [15:0] b,
                           input logic [15:0] s,
                           input logic [2:0] v,
                           input int mute_at,
                           input logic [15:0] exp);
    logic [15:0] lw;
    logic [15:0] rw;
    int zbad;
    int cbad;
    int slot;
    logic prev;
    bgm = b;
    sfx = s;
    volume = v;
    mute = (mute_at == 0);
    lw = '0;
    rw = '0;
    zbad = 0;
    cbad = 0;
    prev = sdin;
    for (int n = 1; n < 2048; n++) begin
      step();
      if (n == mute_at) mute = 1'b1;
      if (mclk !== n[1] || sclk !== n[4] ||
          lrck !== n[10] || sample_tick !== 1'b0)
        cbad++;
      if (n[4:0] != 5'd0 && sdin !== prev) cbad++;
      prev = sdin;
      if (n[4:0] == 5'd16) begin
        slot = int'(n[9:5]);
        if (slot >= 1 && slot <= 16) begin
          if (n[10]) rw = {rw[14:0], sdin};
          else lw = {lw[14:0], sdin};
        end else if (sdin !== 1'b0) begin
          zbad++;
        end
      end
    end
    step();
    chk({tag, " tick"}, 32'(sample_tick), 32'd1);
    chk({tag, " left"}, 32'(lw), 32'(exp));
    chk({tag, " right"}, 32'(rw), 32'(exp));
    chk({tag, " zslots"}, 32'(zbad), 32'd0);
    chk({tag, " clocks"}, 32'(cbad), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bgm = '0;
    sfx = '0;
    volume = '0;
    mute = 1'b0;
    repeat (3) step();
    chk("rst tick", 32'(sample_tick), 32'd0);
    chk("rst mclk", 32'(mclk), 32'd0);
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst lrck", 32'(lrck), 32'd0);
    chk("rst sdin", 32'(sdin), 32'd0);
    rst = 1'b1;
    step();
    chk("first tick", 32'(sample_tick), 32'd1);

    frame_chk("8001", 16'h8001, 16'h0000, 3'd0, -1, 16'h8001);
    frame_chk("sat pos", 16'h7530, 16'h2710, 3'd0, -1,
              DUCK ? 16'h61A8 : 16'h7FFF);
    frame_chk("sat neg", 16'h8AD0, 16'hD8F0, 3'd0, -1,
              DUCK ? 16'h9E58 : 16'h8000);
    frame_chk("max+1", 16'h7FFF, 16'h0001, 3'd0, -1,
              DUCK ? 16'h4000 : 16'h7FFF);
    frame_chk("min-1", 16'h8000, 16'hFFFF, 3'd0, -1,
              DUCK ? 16'hBFFF : 16'h8000);
    frame_chk("big sum", 16'h7530, 16'h7530, 3'd0, -1, 16'h7FFF);
    frame_chk("vol2", 16'h4000, 16'h0000, 3'd2, -1, 16'h1000);
    frame_chk("vol7", 16'hFFFF, 16'h0000, 3'd7, -1, 16'hFFFF);
    frame_chk("vol3 neg", 16'h8000, 16'h0000, 3'd3, -1, 16'hF000);
    frame_chk("duck", 16'h2000, 16'h0100, 3'd0, -1,
              DUCK ? 16'h1100 : 16'h2100);
    frame_chk("mute late", 16'h1234, 16'h0000, 3'd0, 500, 16'h1234);
    frame_chk("mute on", 16'h1234, 16'h0000, 3'd0, 0, 16'h0000);

    bgm = 16'h1234;
    sfx = '0;
    volume = '0;
    mute = 1'b0;
    for (int n = 1; n <= 700; n++) step();
    chk("pre rst sclk", 32'(sclk), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid rst sdin", 32'(sdin), 32'd0);
    chk("mid rst sclk", 32'(sclk), 32'd0);
    chk("mid rst lrck", 32'(lrck), 32'd0);
    chk("mid rst tick", 32'(sample_tick), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("re tick", 32'(sample_tick), 32'd1);
    frame_chk("after rst", 16'h00FF, 16'h0000, 3'd0, -1, 16'h00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_mixer_i2s.md
# audio_mixer_i2s

Final audio stage. Mixes the background-music sample stream with the sound-effect waveform from the hit sound-effect generator, with saturation and volume control. Serializes the mono result, duplicated to left and right, as I2S for the Pmod I2S2 DAC (CS4344). Generates all DAC clocks from the 100 MHz system clock and issues a per-frame sample tick that upstream sources use as their sample-rate strobe.

## Interface
Parameters:
- SAMPLE_W, 16: signed sample width of both inputs and the DAC word.
- VOL_W, 3: width of the attenuation shift amount.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: 100 MHz system clock.
- rst, input, 1: asynchronous, active-low reset.
- bgm_sample, input, 16: signed background-music sample.
- sfx_sample, input, 16: signed sound-effect sample (`sfx_waveform`).
- volume, input, 3: arithmetic right-shift attenuation; 0 means full scale.
- mute, input, 1: forces silence.
- sample_tick, output, 1: one-clk pulse at each frame start.
- mclk, output, 1: DAC master clock, clk/4 (25 MHz).
- sclk, output, 1: serial bit clock, clk/32 (3.125 MHz).
- lrck, output, 1: word select, clk/2048 (48.828 kHz); 0 selects the left channel.
- sdin, output, 1: serial data to the DAC.

## Operation
- Free-running 11-bit frame counter `cnt`, reset to 0, increments every clk and wraps 2047 -> 0.
- Clock derivation:
  - mclk = cnt[1]
  - sclk = cnt[4]
  - lrck = cnt[10]
  - MCLK/LRCK = 512, a valid CS4344 ratio.
- Mix path, combinational, 17-bit signed:
  - sum = sext(bgm) + sext(sfx).
  - Saturate sum to [-32768, 32767].
  - Arithmetic-shift the saturated value right by `volume`.
  - If mute = 1, the mixed result is 0.
- Latch: the mixed result is captured into `word_q` in the clk where cnt == 0. Inputs are sampled only in that cycle; changes mid-frame take effect at the next frame.
- Serialization, I2S format:
  - Within each half-frame, slot s = cnt[9:5] (0..31).
  - Slot 0 carries 0 (the one-bit I2S delay).
  - Slots 1..16 carry word_q[16-s], MSB first.
  - Slots 17..31 carry 0.
  - The left half (lrck = 0) and the right half (lrck = 1) carry the same word_q.
- sample_tick = 1 exactly when cnt == 0.

## Timing
- All outputs are registered and decoded from `cnt`. In the cycle where cnt = N, the outputs reflect N.
- sdin changes only at sclk falling edges (cnt[4:0] == 0). It is stable for 32 clks around each sclk rising edge (cnt[4:0] == 16).
- Latency: inputs are sampled at cnt == 0 of frame F. The MSB appears on sdin at cnt == 32 of frame F, i.e. 32 clks later.
- Reset (rst low, at any time, including mid-word):
  - cnt = 0 and word_q = 0.
  - mclk, sclk, lrck, sdin, sample_tick all = 0.
  - After release, the first frame starts immediately with cnt = 0: sample_tick is high in the first clk.
- Saturation boundaries: 32767 + 1 -> 32767; -32768 + -1 -> -32768. No wrap ever occurs.
- volume = 7 applied to -1 yields -1 (arithmetic shift, no rounding).
- Simultaneous mute and a nonzero sample at a latch cycle: mute wins.

## Configuration
- Macro: `AUDIO_MIXER_DUCK_EN`.
- Defined: when sfx_sample != 0 at the latch cycle, bgm_sample is arithmetic-shifted right by 1 before summing (ducking under effects).
- Undefined: bgm_sample is summed unmodified, and no comparison logic is present.

## Structure
- Shared package `audio_pkg` holds:
  - SAMPLE_W
  - FRAME_CNT_W = 11
  - SLOT_MSB = 1, SLOT_LSB = 16
  - a `sample_t` signed typedef, shared with the sound-effect generator and the BGM player.
- One sub-module, `i2s_serializer`: owns the counter, the clock decode, word_q and sdin. It takes the already-mixed word and emits sample_tick.
- The mix and saturation logic stays in `audio_mixer_i2s`.

## Test plan
- Reset, then release rst: all outputs are 0 during reset. sample_tick pulses at the first clk after release and then every 2048 clks. The lrck, sclk and mclk periods measure 2048, 32 and 4 clks.
- bgm = 0x8001, sfx = 0, volume = 0: both half-frames deliver slot 0 = 0, slots 1..16 = 1000_0000_0000_0001, and slots 17..31 = 0.
- bgm = 30000, sfx = 10000: the DAC word is 0x7FFF. bgm = -30000, sfx = -10000: the DAC word is 0x8000.
- bgm = 0x4000, sfx = 0, volume = 2: word 0x1000. bgm = -1, volume = 7: word 0xFFFF.
- mute raised at cnt = 500 with bgm = 0x1234: the current frame still sends 0x1234 and the next frame sends 0x0000. Asserting rst at cnt = 700 zeroes sdin immediately.
- `AUDIO_MIXER_DUCK_EN` defined, bgm = 0x2000, sfx = 0x0100: word 0x1100. With the macro undefined: word 0x2100.
